ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 119 +++++++++++
 tb/tb_ram_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Latency-modelling RAM slave: a request must be held stable for LAT cycles after
// its first presentation before it completes. busy_o drops only in the completion cycle.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  localparam int AW = $clog2(WORDS);
  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;          // 1 = write, 0 = read
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ramload_q, ramload_d;

  logic [31:0] mem_q [WORDS];

  logic          valid, match, oor, mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  assign valid = Ren ^ Wen;
  assign match = (Wen == op_q) && (Ren == !op_q) && (ramaddr == addr_q) &&
                 (!op_q || (ramstore == data_q));

  // Everything above the word-index field must be zero; byte offset is ignored.
  assign oor     = (addr_q >> (AW + 2)) != 32'd0;
  assign idx     = addr_q[AW+1:2];
  assign rd_word = oor ? BAD_WORD : mem_q[idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ramload_d = ramload_q;
    ramload   = ramload_q;
    busy_o    = 1'b1;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          op_d    = Wen;
          addr_d  = ramaddr;
          data_d  = ramstore;
          cnt_d   = 4'd1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!valid) begin
          state_d = IDLE;
        end else if (!match) begin
          // Controller changed its mind: restart timing on the new request.
          op_d   = Wen;
          addr_d = ramaddr;
          data_d = ramstore;
          cnt_d  = 4'd1;
        end else if (cnt_q < 4'(LAT)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          busy_o  = 1'b0;
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (op_q) begin
            mem_we = !oor;
          end else begin
            ramload   = rd_word;
            ramload_d = rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts anything in flight, including a would-be completion.
    if (RST) begin
      busy_o    = 1'b1;
      mem_we    = 1'b0;
      ramload   = ramload_q;
      state_d   = IDLE;
      cnt_d     = 4'd0;
      op_d      = 1'b0;
      addr_d    = 32'd0;
      data_d    = 32'd0;
      ramload_d = 32'd0;
    end
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    op_q      <= op_d;
    addr_q    <= addr_d;
    data_q    <= data_d;
    ramload_q <= ramload_d;
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx] <= data_q;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (LAT=2, WORDS=256): per-cycle checks of busy_o
// and ramload against hand-computed expectations.
module tb_ram_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        busy_o;

  int passed = 0;
  int total  = 0;

  ram_responder #(.LAT(2), .WORDS(256)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Ren      (Ren),
    .Wen      (Wen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .busy_o   (busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs mid-cycle, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic rst, input logic ren, input logic wen,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic exp_busy, input logic chk_load, input logic [31:0] exp_load);
    RST = rst; Ren = ren; Wen = wen; ramaddr = addr; ramstore = data;
    #1;
    chk({tag, ".busy"}, {31'd0, busy_o}, {31'd0, exp_busy});
    if (chk_load) chk({tag, ".load"}, ramload, exp_load);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input string tag, input logic chk_load, input logic [31:0] exp_load);
    cyc(tag, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, chk_load, exp_load);
  endtask

  // Full write transaction with LAT=2: busy 1,1,0.
  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    cyc(tag, 1'b0, 1'b0, 1'b1, addr, data, 1'b1, 1'b0, 32'h0);
    cyc(tag, 1'b0, 1'b0, 1'b1, addr, data, 1'b1, 1'b0, 32'h0);
    cyc(tag, 1'b0, 1'b0, 1'b1, addr, data, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cyc(tag, 1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(tag, 1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(tag, 1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b1, exp);
  endtask

  initial begin
    RST = 1'b1; Ren = 1'b1; Wen = 1'b1; ramaddr = 32'h0; ramstore = 32'h0;
    @(negedge CLK);
    cyc("rst0", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("rst1", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle("post_rst", 1'b1, 32'h0);

    // Write then read back 0x10.
    wr("wr10", 32'h10, 32'hDEADBEEF);
    idle("gap0", 1'b0, 32'h0);
    rd("rd10", 32'h10, 32'hDEADBEEF);
    idle("hold10", 1'b1, 32'hDEADBEEF);

    // Preload words used later.
    wr("wr14", 32'h14, 32'h14141414);
    wr("wr20", 32'h20, 32'hCAFEF00D);
    wr("wr00", 32'h00, 32'h0000AAAA);
    idle("gap1", 1'b1, 32'hDEADBEEF);

    // Address changes mid-access: restart, complete two cycles later on 0x14.
    cyc("chg.t0", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("chg.t1", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("chg.t2", 1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    cyc("chg.t3", 1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("chg.t4", 1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h14141414);

    // Idle encoding for 5 cycles: never completes, ramload held.
    for (int i = 0; i < 5; i++) idle("idle5", 1'b1, 32'h14141414);
    rd("rd10b", 32'h10, 32'hDEADBEEF);

    // Out-of-range accesses: bit 10 set, must not alias word 0.
    rd("rd400", 32'h400, 32'hBAD1BAD1);
    idle("hold_bad", 1'b1, 32'hBAD1BAD1);
    wr("wr400", 32'h400, 32'h55555555);
    idle("gap2", 1'b1, 32'hBAD1BAD1);
    rd("rd00", 32'h00, 32'h0000AAAA);

    // Reset during a write access aborts it.
    cyc("rstw.t0", 1'b0, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b1, 1'b0, 32'h0);
    cyc("rstw.t1", 1'b1, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b1, 1'b0, 32'h0);
    idle("rstw.t2", 1'b1, 32'h0);
    rd("rd20", 32'h20, 32'hCAFEF00D);

    // Held read restarts after each completion: 1,1,0,1,1,0.
    for (int k = 0; k < 2; k++) begin
      cyc("held.a", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc("held.b", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc("held.c", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    end

    // Write data change mid-access: only the newer data lands.
    cyc("wchg.t0", 1'b0, 1'b0, 1'b1, 32'h14, 32'hAAAA0001, 1'b1, 1'b0, 32'h0);
    cyc("wchg.t1", 1'b0, 1'b0, 1'b1, 32'h14, 32'hBBBB0002, 1'b1, 1'b0, 32'h0);
    cyc("wchg.t2", 1'b0, 1'b0, 1'b1, 32'h14, 32'hBBBB0002, 1'b1, 1'b0, 32'h0);
    cyc("wchg.t3", 1'b0, 1'b0, 1'b1, 32'h14, 32'hBBBB0002, 1'b0, 1'b0, 32'h0);
    idle("gap3", 1'b1, 32'hDEADBEEF);
    rd("rd14", 32'h14, 32'hBBBB0002);

    // Reset landing on what would be a completion cycle suppresses it.
    cyc("rstc.t0", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("rstc.t1", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("rstc.t2", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'hBBBB0002);
    idle("rstc.t3", 1'b1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
